// File: rtl/mmc_pkg.sv
// mmc_pkg: shared definitions for the matmul sequencer.
//   iw(n)    : row/column index width, never below 1 bit
//   cw(n)    : result-RAM address width (holds i*n+j)
//   tag_w(n) : width of a {valid, i, j} tag travelling beside the tree
//   state_e  : controller states
package mmc_pkg;

  function automatic int iw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cw(input int n);
    return 2 * iw(n);
  endfunction

  // {valid, i, j}; valid is the MSB so a pipe can pick it out without knowing n.
  function automatic int tag_w(input int n);
    return 1 + 2 * iw(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mmc_if.sv
// mmc_if: control, operand-RAM, tree and result-RAM signals of matmul_seq_ctrl.
//   master : the sequencer (drives enables, addresses, write port, busy/done)
//   slave  : the environment (drives start, returns tree_dout)
interface mmc_if #(
  parameter int N = 4,
  parameter int K = 8
);
  import mmc_pkg::*;

  localparam int IW = iw(N);
  localparam int CW = cw(N);
  localparam int DW = 2 * K + $clog2(N);

  logic          start;
  logic          busy;
  logic          done;
  logic          a_rd_en;
  logic [IW-1:0] a_addr;
  logic          b_rd_en;
  logic [IW-1:0] b_addr;
  logic [DW-1:0] tree_dout;
  logic          c_we;
  logic [CW-1:0] c_addr;
  logic [DW-1:0] c_wdata;

  modport master (
    input  start, tree_dout,
    output busy, done, a_rd_en, a_addr, b_rd_en, b_addr, c_we, c_addr, c_wdata
  );

  modport slave (
    output start, tree_dout,
    input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr, c_we, c_addr, c_wdata
  );

endinterface

// File: rtl/mmc_tag_pipe.sv
// mmc_tag_pipe: fixed-depth, never-stalling shift register of tags.
//   clk, rst : clock, async active-high reset (clears every stage)
//   tag_i    : tag entering stage 0 (valid bit is the MSB)
//   tag_o    : tag leaving the last stage
//   vld_o    : valid bit of every stage, index 0 = youngest
module mmc_tag_pipe #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     tag_i,
  output logic [W-1:0]     tag_o,
  output logic [DEPTH-1:0] vld_o
);

  logic [DEPTH-1:0][W-1:0] tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int s = 1; s < DEPTH; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_o = tag_q[DEPTH-1];

  for (genvar s = 0; s < DEPTH; s++) begin : g_vld
    assign vld_o[s] = tag_q[s][W-1];
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: drives one shared multiply/add tree through C = A x B.
// Streams (row i, column j) read pairs in row-major order, one per cycle, and
// writes each tree result to address i*n+j once it emerges LAT cycles later.
//   clk, rst    : clock, async active-high reset
//   bus         : mmc_if.master (start/busy/done, A/B reads, tree_dout, C write)
//   perf_cycles : busy-cycle count of the last run (only with MMC_PERF_EN)
// Optional feature macro: MMC_PERF_EN.
module matmul_seq_ctrl
  import mmc_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 8
) (
  input  logic        clk,
  input  logic        rst,
  mmc_if.master       bus
`ifdef MMC_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int IW    = iw(N);
  localparam int CW    = cw(N);
  localparam int TW    = tag_w(N);
  localparam int LAT   = $clog2(N) + 1;
  // One stage for the RAM read, LAT for the tree.
  localparam int DEPTH = 1 + LAT;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
  } tag_t;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic          last_issue;
  tag_t          tag_in, tag_out;
  logic [DEPTH-1:0] pipe_vld;

  assign last_issue = (i_q == IW'(N-1)) && (j_q == IW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ISSUE;
        i_d     = '0;
        j_d     = '0;
      end
      ISSUE: begin
        if (last_issue) begin
          state_d = DRAIN;
          i_d     = '0;
          j_d     = '0;
        end else if (j_q == IW'(N-1)) begin
          j_d = '0;
          i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      // Leave once the final write is at the pipe output with nothing behind it.
      DRAIN: if (pipe_vld == {1'b1, {(DEPTH-1){1'b0}}}) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.a_rd_en = (state_q == ISSUE);
  assign bus.b_rd_en = (state_q == ISSUE);
  assign bus.a_addr  = i_q;
  assign bus.b_addr  = j_q;
  assign bus.busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);

  assign tag_in = '{vld: (state_q == ISSUE), i: i_q, j: j_q};

  mmc_tag_pipe #(.W(TW), .DEPTH(DEPTH)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out),
    .vld_o (pipe_vld)
  );

  // Write port is quiet (address and data zero) whenever no write is due.
  assign bus.c_we    = tag_out.vld;
  assign bus.c_addr  = tag_out.vld ? (CW'(tag_out.i) * CW'(N) + CW'(tag_out.j)) : '0;
  assign bus.c_wdata = tag_out.vld ? bus.tree_dout : '0;

`ifdef MMC_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              perf_q <= '0;
    else if (state_q == IDLE && bus.start) perf_q <= '0;
    else if (bus.busy)                    perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: random and directed matrix products against a
// behavioural 1-cycle RAM + LAT-cycle tree and a reference product/timeline.
module tb_matmul_seq_ctrl;
  import mmc_pkg::*;

  localparam int N   = 4;
  localparam int K   = 8;
  localparam int LAT = 3;
  localparam int DW  = 2 * K + 2;
  localparam int NN  = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmc_if #(.N(N), .K(K)) bus();
`ifdef MMC_PERF_EN
  logic [31:0] perf_cycles;
`endif

  matmul_seq_ctrl #(.N(N), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MMC_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  // Operand RAMs, 1-cycle read, then a tree with LAT cycles of latency.
  logic [K-1:0]  A [N][N];
  logic [K-1:0]  B [N][N];
  logic [K-1:0]  a_row [N];
  logic [K-1:0]  b_col [N];
  logic [DW-1:0] dot;
  logic [DW-1:0] dly [LAT];

  always @(posedge clk) begin
    if (bus.a_rd_en) for (int m = 0; m < N; m++) a_row[m] <= A[bus.a_addr][m];
    if (bus.b_rd_en) for (int m = 0; m < N; m++) b_col[m] <= B[m][bus.b_addr];
    dly[0] <= dot;
    for (int s = 1; s < LAT; s++) dly[s] <= dly[s-1];
  end

  always_comb begin
    dot = '0;
    for (int m = 0; m < N; m++) dot = dot + DW'(a_row[m]) * DW'(b_col[m]);
  end

  assign bus.tree_dout = dly[LAT-1];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (kind)
          1: begin A[r][c] = (r == c) ? 8'd1 : 8'd0; B[r][c] = 8'(r * N + c); end
          2: begin A[r][c] = 8'hFF; B[r][c] = 8'hFF; end
          default: begin A[r][c] = 8'($urandom); B[r][c] = 8'($urandom); end
        endcase
      end
  endtask

  // mode 0: clean run; 1: stray start at cycle 7; 2: reset at cycle 10
  task automatic do_run(input int mode);
    logic [DW-1:0] cexp [NN];
    logic [3:0] fl, ef;
    int wr = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cexp[i*N+j] = '0;
        for (int m = 0; m < N; m++)
          cexp[i*N+j] = cexp[i*N+j] + DW'(A[i][m]) * DW'(B[m][j]);
      end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int t = 1; t <= 26; t++) begin
      @(negedge clk);
      fl = {bus.a_rd_en, bus.busy, bus.c_we, bus.done};
      ef = {t <= NN, t <= NN + LAT + 1, (t >= LAT + 2) && (t <= LAT + 1 + NN), t == LAT + 2 + NN};
      chk($sformatf("flags@%0d", t), 64'(fl), 64'(ef));
      if (ef[3]) chk($sformatf("rd_addr@%0d", t), 64'({bus.a_addr, bus.b_addr}),
                     64'(((t - 1) / N) * 4 + (t - 1) % N));
      if (bus.c_we && wr < NN) begin
        chk($sformatf("c_addr#%0d", wr), 64'(bus.c_addr), 64'(wr));
        chk($sformatf("c_wdata#%0d", wr), 64'(bus.c_wdata), 64'(cexp[wr]));
        wr++;
      end
`ifdef MMC_PERF_EN
      if (t == LAT + 2 + NN || t == 26) chk($sformatf("perf@%0d", t), 64'(perf_cycles), 64'(NN + LAT + 1));
`endif
      if (mode == 1) bus.start = (t == 7);
      if (mode == 2 && t == 10) begin
        rst = 1'b1;
        #1;
        chk("abort", 64'({bus.c_we, bus.busy, bus.a_rd_en, bus.done}), 64'(0));
`ifdef MMC_PERF_EN
        chk("perf_rst", 64'(perf_cycles), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    chk("writes", 64'(wr), 64'(NN));
  endtask

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_flags", 64'({bus.a_rd_en, bus.b_rd_en, bus.busy, bus.c_we, bus.done}), 64'(0));
    chk("rst_addr", 64'({bus.a_addr, bus.b_addr, bus.c_addr}), 64'(0));
`ifdef MMC_PERF_EN
    chk("rst_perf", 64'(perf_cycles), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    fill(0); do_run(0);
    fill(1); do_run(0);
    fill(2); do_run(0);
    fill(0); do_run(1);
    fill(0); do_run(2);
    fill(0); do_run(0);
    fill(0); do_run(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
